// File: rtl/tl45_muldiv_seq.sv
// tl45_muldiv_seq: iterative radix-2 multiply/divide sequencer beside the ALU stage
//
// Ports:
//   i_clk, i_reset           clock (rising edge) and synchronous active-high reset
//   i_pipe_stall             downstream stall; a finished result is held while high
//   o_pipe_stall             stall to earlier stages (downstream stall or this unit busy)
//   i_pipe_flush             abort any operation in progress and clear the outputs
//   o_pipe_flush             copy of i_pipe_flush; this unit never starts a flush
//   i_opcode                 decode-buffer opcode; MUL (5'h3) and DIV (5'h4) are taken here
//   i_dr                     destination register of the incoming instruction
//   i_sr1_val, i_sr2_val     operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   o_of_reg, o_of_val       operand forward, non-zero only while a result waits to retire
//   o_dr, o_value            registered destination and result to the next stage
//   o_busy                   high while an operation is running or waiting to retire
module tl45_muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    output logic        o_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_flush,
    input  logic [4:0]  i_opcode,
    input  logic [3:0]  i_dr,
    input  logic [31:0] i_sr1_val,
    input  logic [31:0] i_sr2_val,
    output logic [3:0]  o_of_reg,
    output logic [31:0] o_of_val,
    output logic [3:0]  o_dr,
    output logic [31:0] o_value,
    output logic        o_busy
);
    localparam logic [4:0] OP_MUL = 5'h3;
    localparam logic [4:0] OP_DIV = 5'h4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  dr_q, dr_d;
    logic        div_q, div_d;
    logic [3:0]  o_dr_q, o_dr_d;
    logic [31:0] o_value_q, o_value_d;
    logic        accept;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] result;

    assign accept = (state_q == IDLE) && !i_pipe_flush &&
                    ((i_opcode == OP_MUL) || (i_opcode == OP_DIV));
    // Division keeps the remainder in acc_q and shifts the quotient into a_q,
    // where the dividend bits are consumed from the top as quotient bits enter below.
    assign rem_sh = {acc_q, a_q[31]};
    assign trial  = rem_sh - {1'b0, b_q};
    assign result = div_q ? a_q : acc_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            dr_q      <= '0;
            div_q     <= 1'b0;
            o_dr_q    <= '0;
            o_value_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            dr_q      <= dr_d;
            div_q     <= div_d;
            o_dr_q    <= o_dr_d;
            o_value_q <= o_value_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        dr_d      = dr_q;
        div_d     = div_q;
        o_dr_d    = o_dr_q;
        o_value_d = o_value_q;
        if (i_pipe_flush) begin
            state_d   = IDLE;
            cnt_d     = '0;
            a_d       = '0;
            b_d       = '0;
            acc_d     = '0;
            dr_d      = '0;
            div_d     = 1'b0;
            o_dr_d    = '0;
            o_value_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_d     = i_sr1_val;
                        b_d     = i_sr2_val;
                        dr_d    = i_dr;
                        div_d   = (i_opcode == OP_DIV);
                        cnt_d   = 5'(ITER - 1);
                        acc_d   = '0;
                        state_d = BUSY;
                    end else begin
                        o_dr_d    = '0;
                        o_value_d = '0;
                    end
                end
                BUSY: begin
                    if (div_q) begin
                        // A negative trial (bit 32 set) restores the shifted remainder.
                        acc_d = trial[32] ? rem_sh[31:0] : trial[31:0];
                        a_d   = {a_q[30:0], ~trial[32]};
                    end else begin
                        acc_d = acc_q + (b_q[0] ? a_q : 32'd0);
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0)
                        state_d = DONE;
                end
                DONE: begin
                    if (!i_pipe_stall) begin
                        o_dr_d    = dr_q;
                        o_value_d = result;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_pipe_stall = i_pipe_stall | accept | (state_q == BUSY);
        o_pipe_flush = i_pipe_flush;
        o_busy       = (state_q != IDLE);
        o_of_reg     = (state_q == DONE) ? dr_q : 4'd0;
        o_of_val     = (state_q == DONE) ? result : 32'd0;
        o_dr         = o_dr_q;
        o_value      = o_value_q;
    end
endmodule

// File: tb/tb_tl45_muldiv_seq.sv
// tb_tl45_muldiv_seq: scoreboard bench for the multiply/divide sequencer
module tb_tl45_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pstall = 1'b0;
    logic        pflush = 1'b0;
    logic [4:0]  opcode = 5'h0;
    logic [3:0]  dri = 4'h0;
    logic [31:0] sr1 = 32'h0;
    logic [31:0] sr2 = 32'h0;
    logic        o_pipe_stall, o_pipe_flush, o_busy;
    logic [3:0]  o_of_reg, o_dr;
    logic [31:0] o_of_val, o_value;
    logic [35:0] exp_q[$];
    logic [35:0] e;
    int          checks = 0;
    int          errors = 0;

    tl45_muldiv_seq dut (
        .i_clk(clk), .i_reset(rst), .i_pipe_stall(pstall), .o_pipe_stall(o_pipe_stall),
        .i_pipe_flush(pflush), .o_pipe_flush(o_pipe_flush), .i_opcode(opcode), .i_dr(dri),
        .i_sr1_val(sr1), .i_sr2_val(sr2), .o_of_reg(o_of_reg), .o_of_val(o_of_val),
        .o_dr(o_dr), .o_value(o_value), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic div, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return div ? ((b == 32'd0) ? 32'hFFFF_FFFF : a / b) : p[31:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && o_busy && !o_pipe_stall) begin
            if (exp_q.size() == 0) chk("unexpected_retire", 36'd1, 36'd0);
            else begin
                e = exp_q.pop_front();
                chk("fwd_reg", {32'd0, o_of_reg}, {32'd0, e[35:32]});
                chk("fwd_val", {4'd0, o_of_val}, {4'd0, e[31:0]});
                @(posedge clk);
                #1;
                chk("ret_dr", {32'd0, o_dr}, {32'd0, e[35:32]});
                chk("ret_val", {4'd0, o_value}, {4'd0, e[31:0]});
            end
        end
    end

    task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] dr, input int hold);
        int n;
        bit done;
        logic [3:0] h_dr;
        logic [31:0] h_val;
        @(posedge clk);
        #2;
        opcode = div ? 5'h4 : 5'h3;
        sr1 = a; sr2 = b; dri = dr; pstall = 1'b0;
        exp_q.push_back({dr, model(div, a, b)});
        n = 0; done = 0; h_dr = '0; h_val = '0;
        for (int t = 0; t < 200 && !done; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #2;
                opcode = 5'h1; sr1 = $urandom; sr2 = $urandom; dri = 4'($urandom);
                pstall = (t >= 33 && t < 33 + hold);
            end
            #2;
            if (t == 0) chk("accept_stall", {35'd0, o_pipe_stall}, 36'd1);
            if (o_pipe_stall && !pstall) n++;
            if (t == 33) begin h_dr = o_dr; h_val = o_value; end
            if (t > 33 && pstall) begin
                chk("hold_dr", {32'd0, o_dr}, {32'd0, h_dr});
                chk("hold_val", {4'd0, o_value}, {4'd0, h_val});
                chk("hold_busy", {35'd0, o_busy}, 36'd1);
            end
            if (t > 0 && !o_busy) begin
                done = 1;
                chk("latency", 36'(t), 36'(34 + hold));
                chk("stall_cycles", 36'(n), 36'd33);
            end
        end
        if (!done) chk("timeout", 36'd0, 36'd1);
    endtask

    task automatic abort_op(input logic use_reset);
        opcode = 5'h3; sr1 = $urandom; sr2 = $urandom; dri = 4'hA; pstall = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk);
            #2;
            opcode = 5'h1;
        end
        if (use_reset) rst = 1'b1; else pflush = 1'b1;
        #2;
        chk("flush_mirror", {35'd0, o_pipe_flush}, {35'd0, !use_reset});
        @(posedge clk);
        #2;
        rst = 1'b0; pflush = 1'b0;
        #2;
        chk("abort_busy", {35'd0, o_busy}, 36'd0);
        chk("abort_dr", {32'd0, o_dr}, 36'd0);
        chk("abort_val", {4'd0, o_value}, 36'd0);
        chk("abort_stall", {35'd0, o_pipe_stall}, 36'd0);
        chk("abort_fwd", {o_of_reg, o_of_val}, 36'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #2;
        chk("rst_busy", {35'd0, o_busy}, 36'd0);
        chk("rst_out", {o_dr, o_value}, 36'd0);
        chk("rst_stall", {35'd0, o_pipe_stall}, 36'd0);
        run_op(1'b0, 32'd7, 32'd6, 4'd3, 0);
        chk("add_stall", {35'd0, o_pipe_stall}, 36'd0);
        @(posedge clk);
        #1;
        chk("add_clear", {o_dr, o_value}, 36'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 0);
        run_op(1'b1, 32'd100, 32'd7, 4'd9, 0);
        run_op(1'b1, 32'd5, 32'd0, 4'd2, 0);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 4'd0, 3);
        abort_op(1'b0);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd15, 1);
        abort_op(1'b1);
        for (int i = 0; i < 14; i++)
            run_op(1'($urandom), $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom,
                   4'($urandom), int'($urandom_range(0, 2)));
        repeat (3) @(posedge clk);
        #2;
        chk("queue_empty", 36'(exp_q.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
